// File: rtl/stage_e_pipe_if.sv
// Bundle of decode-side inputs and E/M-side outputs of the execute stage.
// The slave modport is the execute stage; the master drives decode, stall and forwarding.
interface stage_e_pipe_if;
  logic        stall;
  logic [31:0] instrD;
  logic [31:0] pcD;
  logic [31:0] rd1D;
  logic [31:0] rd2D;
  logic [1:0]  forward_rs_alu;
  logic [1:0]  forward_rt_alu;
  logic [31:0] resultW;
  logic [31:0] instrE;
  logic [31:0] instrM;
  logic [31:0] pcM;
  logic [31:0] resultM;
  logic [31:0] wdataM;

  modport master (
    output stall, instrD, pcD, rd1D, rd2D, forward_rs_alu, forward_rt_alu, resultW,
    input  instrE, instrM, pcM, resultM, wdataM
  );

  modport slave (
    input  stall, instrD, pcD, rd1D, rd2D, forward_rs_alu, forward_rt_alu, resultW,
    output instrE, instrM, pcM, resultM, wdataM
  );
endinterface

// File: rtl/stage_e_pipe.sv
// MIPS execute stage: ID/EX register with stall bubbles, rs/rt forwarding muxes,
// integer ALU and the EX/MEM register.
module stage_e_pipe (
  input  logic           clk,
  input  logic           reset,
  stage_e_pipe_if.slave  bus
);

  logic [31:0] instr_e_q, pc_e_q, rs_e_q, rt_e_q;
  logic [31:0] instr_e_d, pc_e_d, rs_e_d, rt_e_d;
  logic [31:0] instr_m_q, pc_m_q, result_m_q, wdata_m_q;
  logic [31:0] instr_m_d, pc_m_d, result_m_d, wdata_m_d;
  logic [31:0] src_a_s, src_b_s, alu_s;
  logic [5:0]  op_s, funct_s;
  logic [15:0] imm_s;

  assign op_s    = instr_e_q[31:26];
  assign funct_s = instr_e_q[5:0];
  assign imm_s   = instr_e_q[15:0];

  // ID/EX next state: a stall replaces the decode instruction with a nop bubble.
  always_comb begin
    instr_e_d = 32'h0;
    pc_e_d    = 32'h0;
    rs_e_d    = 32'h0;
    rt_e_d    = 32'h0;
    if (bus.stall) begin
      instr_e_d = 32'h0;
      pc_e_d    = 32'h0;
      rs_e_d    = 32'h0;
      rt_e_d    = 32'h0;
    end else begin
      instr_e_d = bus.instrD;
      pc_e_d    = bus.pcD;
      rs_e_d    = bus.rd1D;
      rt_e_d    = bus.rd2D;
    end
  end

  // Operand forwarding; code 3 is unused and falls back to the latched value.
  always_comb begin
    src_a_s = rs_e_q;
    case (bus.forward_rs_alu)
      2'd1:    src_a_s = result_m_q;
      2'd2:    src_a_s = bus.resultW;
      default: src_a_s = rs_e_q;
    endcase
    src_b_s = rt_e_q;
    case (bus.forward_rt_alu)
      2'd1:    src_b_s = result_m_q;
      2'd2:    src_b_s = bus.resultW;
      default: src_b_s = rt_e_q;
    endcase
  end

  // ALU; anything not decoded here (nop, branches, jr, j) yields zero.
  always_comb begin
    alu_s = 32'h0;
    case (op_s)
      6'h00: begin
        case (funct_s)
          6'h21:   alu_s = src_a_s + src_b_s;
          6'h23:   alu_s = src_a_s - src_b_s;
          default: alu_s = 32'h0;
        endcase
      end
      6'h0d:        alu_s = src_a_s | {16'h0, imm_s};
      6'h0f:        alu_s = {imm_s, 16'h0};
      6'h23, 6'h2b: alu_s = src_a_s + {{16{imm_s[15]}}, imm_s};
      6'h03:        alu_s = pc_e_q + 32'd8;
      default:      alu_s = 32'h0;
    endcase
  end

  // EX/MEM next state: loads every cycle regardless of stall.
  always_comb begin
    instr_m_d  = instr_e_q;
    pc_m_d     = pc_e_q;
    result_m_d = alu_s;
    wdata_m_d  = src_b_s;
  end

  // Pipeline registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_e_q  <= 32'h0;
      pc_e_q     <= 32'h0;
      rs_e_q     <= 32'h0;
      rt_e_q     <= 32'h0;
      instr_m_q  <= 32'h0;
      pc_m_q     <= 32'h0;
      result_m_q <= 32'h0;
      wdata_m_q  <= 32'h0;
    end else begin
      instr_e_q  <= instr_e_d;
      pc_e_q     <= pc_e_d;
      rs_e_q     <= rs_e_d;
      rt_e_q     <= rt_e_d;
      instr_m_q  <= instr_m_d;
      pc_m_q     <= pc_m_d;
      result_m_q <= result_m_d;
      wdata_m_q  <= wdata_m_d;
    end
  end

  assign bus.instrE  = instr_e_q;
  assign bus.instrM  = instr_m_q;
  assign bus.pcM     = pc_m_q;
  assign bus.resultM = result_m_q;
  assign bus.wdataM  = wdata_m_q;

endmodule

// File: tb/tb_stage_e_pipe.sv
// Directed self-checking bench for stage_e_pipe; one task per scenario.
module tb_stage_e_pipe;
  logic clk = 1'b0;
  logic reset;
  int errors = 0;
  int checks = 0;

  localparam logic [31:0] ADDU = 32'h00221821;
  localparam logic [31:0] SUBU = 32'h00221823;
  localparam logic [31:0] ORI0 = 32'h34210000;
  localparam logic [31:0] NOP  = 32'h00000000;

  stage_e_pipe_if bus();
  stage_e_pipe dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                       input logic [31:0] rd1, input logic [31:0] rd2);
    bus.instrD = instr;
    bus.pcD    = pc;
    bus.rd1D   = rd1;
    bus.rd2D   = rd2;
  endtask

  task automatic test_reset();
    drive(ADDU, 32'h100, 32'd1, 32'd2);
    reset = 1'b1;
    tick();
    bus.stall = 1'b1;
    tick();
    checks++; if (bus.instrE !== 32'h0) begin errors++; $display("FAIL reset_instrE: got %h expected 0", bus.instrE); end
    checks++; if (bus.instrM !== 32'h0) begin errors++; $display("FAIL reset_instrM: got %h expected 0", bus.instrM); end
    checks++; if (bus.pcM !== 32'h0) begin errors++; $display("FAIL reset_pcM: got %h expected 0", bus.pcM); end
    checks++; if (bus.resultM !== 32'h0) begin errors++; $display("FAIL reset_resultM: got %h expected 0", bus.resultM); end
    checks++; if (bus.wdataM !== 32'h0) begin errors++; $display("FAIL reset_wdataM: got %h expected 0", bus.wdataM); end
    reset = 1'b0;
    bus.stall = 1'b0;
    tick();
    checks++; if (bus.instrE !== ADDU) begin errors++; $display("FAIL release_instrE: got %h expected %h", bus.instrE, ADDU); end
    checks++; if (bus.instrM !== 32'h0) begin errors++; $display("FAIL release_instrM_early: got %h expected 0", bus.instrM); end
    tick();
    checks++; if (bus.instrM !== ADDU) begin errors++; $display("FAIL release_instrM: got %h expected %h", bus.instrM, ADDU); end
    checks++; if (bus.pcM !== 32'h100) begin errors++; $display("FAIL release_pcM: got %h expected 100", bus.pcM); end
    checks++; if (bus.resultM !== 32'd3) begin errors++; $display("FAIL release_resultM: got %h expected 3", bus.resultM); end
    checks++; if (bus.wdataM !== 32'd2) begin errors++; $display("FAIL release_wdataM: got %h expected 2", bus.wdataM); end
    // Mid-stream reset discards both E and M.
    drive(SUBU, 32'h104, 32'd9, 32'd4);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (bus.instrE !== 32'h0 || bus.instrM !== 32'h0) begin
      errors++; $display("FAIL midreset_flush: got E=%h M=%h expected 0/0", bus.instrE, bus.instrM);
    end
    drive(NOP, 32'h0, 32'h0, 32'h0);
    tick();
  endtask

  task automatic test_alu();
    logic [31:0] v_instr [9] = '{ADDU, SUBU, ORI0 | 32'h00FF, 32'h3C01ABCD, 32'h8C22FFFC,
                                 32'hAC220008, 32'h10220003, 32'h00200008, 32'h00221824};
    logic [31:0] v_rd1 [9] = '{32'h7FFFFFFF, 32'h0, 32'h12340000, 32'h5555, 32'h1000,
                               32'h20, 32'h7, 32'h40, 32'hFF};
    logic [31:0] v_rd2 [9] = '{32'h1, 32'h1, 32'h0, 32'h0, 32'h0, 32'h77, 32'h7, 32'h0, 32'h0F};
    logic [31:0] v_exp [9] = '{32'h80000000, 32'hFFFFFFFF, 32'h123400FF, 32'hABCD0000,
                               32'h00000FFC, 32'h00000028, 32'h0, 32'h0, 32'h0};
    for (int i = 0; i < 9; i++) begin
      drive(v_instr[i], 32'h400 + 32'(i * 4), v_rd1[i], v_rd2[i]);
      tick();
      drive(NOP, 32'h0, 32'h0, 32'h0);
      tick();
      checks++; if (bus.resultM !== v_exp[i]) begin
        errors++; $display("FAIL alu_result[%0d]: got %h expected %h", i, bus.resultM, v_exp[i]);
      end
      checks++; if (bus.wdataM !== v_rd2[i]) begin
        errors++; $display("FAIL alu_wdata[%0d]: got %h expected %h", i, bus.wdataM, v_rd2[i]);
      end
    end
  endtask

  task automatic test_jal();
    drive(32'h0C000C00, 32'h00003000, 32'h0, 32'h0);
    tick();
    drive(NOP, 32'h0, 32'h0, 32'h0);
    tick();
    checks++; if (bus.resultM !== 32'h00003008) begin errors++; $display("FAIL jal_result: got %h expected 00003008", bus.resultM); end
    checks++; if (bus.pcM !== 32'h00003000) begin errors++; $display("FAIL jal_pcM: got %h expected 00003000", bus.pcM); end
  endtask

  task automatic test_forward(input logic [1:0] rs_c, input logic [1:0] rt_c,
                              input logic [31:0] exp_res, input logic [31:0] exp_wd);
    drive(ORI0, 32'h500, 32'h11, 32'h0);
    tick();
    drive(ADDU, 32'h504, 32'h33, 32'h33);
    tick();
    checks++; if (bus.resultM !== 32'h11) begin errors++; $display("FAIL fwd_producer: got %h expected 11", bus.resultM); end
    bus.forward_rs_alu = rs_c;
    bus.forward_rt_alu = rt_c;
    bus.resultW = 32'h22;
    drive(NOP, 32'h0, 32'h0, 32'h0);
    tick();
    bus.forward_rs_alu = 2'd0;
    bus.forward_rt_alu = 2'd0;
    checks++; if (bus.resultM !== exp_res) begin
      errors++; $display("FAIL fwd_result rs=%0d rt=%0d: got %h expected %h", rs_c, rt_c, bus.resultM, exp_res);
    end
    checks++; if (bus.wdataM !== exp_wd) begin
      errors++; $display("FAIL fwd_wdata rs=%0d rt=%0d: got %h expected %h", rs_c, rt_c, bus.wdataM, exp_wd);
    end
  endtask

  task automatic test_store();
    drive(ORI0, 32'h600, 32'hDEAD, 32'h0);
    tick();
    drive(32'hAC220004, 32'h604, 32'h100, 32'h5);
    tick();
    bus.forward_rt_alu = 2'd1;
    drive(NOP, 32'h0, 32'h0, 32'h0);
    tick();
    bus.forward_rt_alu = 2'd0;
    checks++; if (bus.wdataM !== 32'hDEAD) begin errors++; $display("FAIL store_wdata: got %h expected 0000dead", bus.wdataM); end
    checks++; if (bus.resultM !== 32'h104) begin errors++; $display("FAIL store_addr: got %h expected 104", bus.resultM); end
  endtask

  task automatic test_stall();
    drive(ADDU, 32'h200, 32'd5, 32'd6);
    tick();
    drive(SUBU, 32'h204, 32'd9, 32'd4);
    bus.stall = 1'b1;
    tick();
    bus.stall = 1'b0;
    checks++; if (bus.instrE !== 32'h0) begin errors++; $display("FAIL stall_bubble_E: got %h expected 0", bus.instrE); end
    checks++; if (bus.instrM !== ADDU || bus.resultM !== 32'd11) begin
      errors++; $display("FAIL stall_advance_M: got %h/%h expected %h/0000000b", bus.instrM, bus.resultM, ADDU);
    end
    drive(NOP, 32'h0, 32'h0, 32'h0);
    tick();
    checks++; if (bus.instrM !== 32'h0 || bus.resultM !== 32'h0 || bus.pcM !== 32'h0) begin
      errors++; $display("FAIL stall_bubble_M: got %h/%h/%h expected 0/0/0", bus.instrM, bus.resultM, bus.pcM);
    end
  endtask

  task automatic test_back_to_back();
    drive(ADDU, 32'h700, 32'd1, 32'd2);
    tick();
    drive(ADDU, 32'h704, 32'd0, 32'd10);
    tick();
    bus.forward_rs_alu = 2'd1;
    drive(ADDU, 32'h708, 32'd0, 32'd100);
    tick();
    checks++; if (bus.resultM !== 32'd13) begin errors++; $display("FAIL b2b_first: got %h expected 0000000d", bus.resultM); end
    drive(NOP, 32'h0, 32'h0, 32'h0);
    tick();
    bus.forward_rs_alu = 2'd0;
    checks++; if (bus.resultM !== 32'd113) begin errors++; $display("FAIL b2b_second: got %h expected 00000071", bus.resultM); end
  endtask

  initial begin
    reset = 1'b1;
    bus.stall = 1'b0;
    bus.forward_rs_alu = 2'd0;
    bus.forward_rt_alu = 2'd0;
    bus.resultW = 32'h999;
    drive(NOP, 32'h0, 32'h0, 32'h0);
    test_reset();
    test_alu();
    test_jal();
    test_forward(2'd1, 2'd2, 32'h33, 32'h22);
    test_forward(2'd2, 2'd0, 32'h55, 32'h33);
    test_forward(2'd0, 2'd3, 32'h66, 32'h33);
    test_forward(2'd3, 2'd1, 32'h44, 32'h11);
    test_store();
    test_stall();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/stage_e_pipe.md
# stage_e_pipe

Execute-stage datapath for the 5-stage MIPS pipeline: ID/EX pipeline register (with bubble insertion on stall), the rs/rt operand forwarding muxes driven by the forwarding units' 2-bit select codes, the integer ALU, and the EX/MEM pipeline register. Sits between the decode stage (register file read) and the memory stage. Publishes `instrE` and `instrM` back to the forwarding and stall units.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high; clears both pipeline registers
- `stall`  in  1  from the stall unit; the ID/EX register loads a bubble this edge
- `instrD`  in  32  instruction leaving decode
- `pcD`  in  32  PC of `instrD`
- `rd1D`  in  32  register-file read of rs(`instrD`)
- `rd2D`  in  32  register-file read of rt(`instrD`)
- `forward_rs_alu`  in  2  rs select for E: 0 latched regfile value, 1 `resultM`, 2 `resultW`, 3 treated as 0
- `forward_rt_alu`  in  2  rt select for E, same encoding
- `resultW`  in  32  write-back data of the W stage
- `instrE`  out  32  instruction currently in E (registered)
- `instrM`  out  32  instruction currently in M (registered)
- `pcM`  out  32  PC of `instrM`
- `resultM`  out  32  ALU result / link address of `instrM`
- `wdataM`  out  32  forwarded rt value of `instrM` (store data)

## Operation
- ID/EX register holds `instrE`, `pcE`, `rsE`, `rtE`.
  - `reset`: all fields 0 (`instr` 0 = `sll $0,$0,0` = nop).
  - else `stall`: `instrE`, `pcE`, `rsE`, `rtE` <= 0 (bubble). Holding decode is not this block's job.
  - else: load `instrD`, `pcD`, `rd1D`, `rd2D`.
- Forwarding, combinational in E:
  - `srcA` = {`rsE`, `resultM`, `resultW`, `rsE`}[`forward_rs_alu`].
  - `srcB` = same indexing over `rtE` with `forward_rt_alu`.
- ALU, decoded from `instrE` (op = [31:26], funct = [5:0], imm = [15:0]):
  - R-type, funct 0x21 (addu): `srcA`+`srcB` mod 2^32, no overflow trap.
  - R-type, funct 0x23 (subu): `srcA`-`srcB` mod 2^32.
  - op 0x0d (ori): `srcA` | zero-extend(imm).
  - op 0x0f (lui): {imm, 16'h0}.
  - op 0x23 (lw), op 0x2b (sw): `srcA` + sign-extend(imm).
  - op 0x03 (jal): `pcE` + 8.
  - Any other instruction, including nop, jr, beq, j: 0.
- EX/MEM register holds `instrM`, `pcM`, `resultM`, `wdataM`.
  - `reset`: all 0.
  - Otherwise loads every cycle, unconditionally: `instrE`, `pcE`, ALU result, `srcB`.
  - `stall` does not affect EX/MEM. The bubble in E flows on as a nop.

## Timing
- Latency: `instrD` sampled at edge n appears on `instrE` after edge n and on `instrM` after edge n+1.
- `resultM` is registered, so a code-1 forward always uses the previous instruction's result.
- Back-to-back dependence forwards with no stall:
  - addu; addu uses code 1.
  - One instruction between producer and consumer uses code 2.
- Load-use hazards are resolved upstream by `stall`. This block never forwards memory read data from M.
- `reset` and `stall` both high: `reset` wins. The result is identical for the ID/EX register (all 0), and EX/MEM is also cleared.
- `reset` mid-stream: every in-flight E and M instruction is discarded in the same edge. The first valid `instrM` appears two edges after `reset` falls.
- Forward selects are sampled combinationally in the same cycle as `instrE`. No internal registering of the codes.

## Test plan
- Reset: assert `reset` for 2 cycles with nonzero D inputs -> `instrE`, `instrM`, `pcM`, `resultM`, `wdataM` all 0. Release -> D values reach `instrM` after 2 edges.
- ALU ops:
  - `rd1D`=0x7FFFFFFF, `rd2D`=1, addu, codes 0 -> `resultM`=0x80000000.
  - subu 0 - 1 -> 0xFFFFFFFF.
  - ori with rs=0x12340000, imm 0x00FF -> 0x123400FF.
  - lui imm 0xABCD -> 0xABCD0000.
  - lw with rs=0x1000, imm 0xFFFC -> 0x00000FFC.
- jal at `pcD`=0x00003000 -> `resultM`=0x00003008, `pcM`=0x00003000.
- Forwarding: prior `resultM`=0x11, `resultW`=0x22, `rsE`=`rtE`=0x33, addu.
  - rs code 1, rt code 2 -> 0x33.
  - rs code 2, rt code 0 -> 0x55.
  - rt code 3 -> `srcB` 0x33.
- Store data: sw with `rtE`=0x5, `forward_rt_alu`=1, prior `resultM`=0xDEAD -> `wdataM`=0xDEAD.
- Stall: valid addu in D, `stall`=1 for one edge -> `instrE`=0 for that cycle, then `instrM`=0 and `resultM`=0 next edge. An instruction already in E still advances to M during the stall edge.
